// File: rtl/udp_frame_recv_if.sv
// Bus bundle for the UDP frame receiver: upstream packet port, unused
// write-back port, and the DRAM write-data / command FIFO pushes.
// "master" is the environment side, "slave" is the receiver.
interface udp_frame_recv_if;

    // Upstream packet port
    logic        r_req;
    logic        r_enable;
    logic        r_ack;
    logic [31:0] r_data;

    // Write-back port (not used by this receiver)
    logic        w_req;
    logic        w_enable;
    logic        w_ack;
    logic [31:0] w_data;

    // DRAM write-data FIFO: {strb[3:0], data[31:0]}
    logic [35:0] data_in;
    logic        data_we;

    // DRAM command FIFO: {len[7:0] words, byte addr[31:0]}
    logic [39:0] ctrl_in;
    logic        ctrl_we;
    logic        ctrl_ready;

    modport master (
        output r_req, r_enable, r_data, w_ack, ctrl_ready,
        input  r_ack, w_req, w_enable, w_data, data_in, data_we, ctrl_in, ctrl_we
    );

    modport slave (
        input  r_req, r_enable, r_data, w_ack, ctrl_ready,
        output r_ack, w_req, w_enable, w_data, data_in, data_we, ctrl_in, ctrl_we
    );

endinterface

// File: rtl/udp_frame_recv.sv
// UDP video frame receiver. Parses one packet per r_enable burst (header,
// word offset, payload), streams the payload into the DRAM write-data FIFO
// with tail byte strobes, then issues burst-split write commands. Frames
// rotate among NUM_BUF buffers whenever a valid packet carries offset 0.
module udp_frame_recv #(
    parameter int          NUM_BUF       = 2,
    parameter logic [31:0] FRAME_BASE    = 32'h0000_0000,
    parameter logic [31:0] FRAME_STRIDE  = 32'h0200_0000,
    parameter int          HDR_WORDS     = 4,
    parameter int          LEN_IDX       = 3,
    parameter int          MAX_BURST     = 64,
    parameter int          MAX_PKT_WORDS = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    udp_frame_recv_if.slave            bus,
    output logic [$clog2(NUM_BUF)-1:0] frame_select,
    output logic                       frame_done,
    output logic [15:0]                pkt_cnt,
    output logic [15:0]                drop_cnt
);

    localparam int SEL_W     = $clog2(NUM_BUF);
    localparam int CNT_MAX   = (MAX_PKT_WORDS > HDR_WORDS) ? MAX_PKT_WORDS : HDR_WORDS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    // A burst can never exceed the largest packet, so cap it there to keep
    // the constant representable in the remaining-word counter.
    localparam int BURST_CAP = (MAX_BURST < MAX_PKT_WORDS) ? MAX_BURST : MAX_PKT_WORDS;

    localparam logic [CNT_W-1:0] LEN_IDX_C   = CNT_W'(LEN_IDX);
    localparam logic [CNT_W-1:0] HDR_LAST_C  = CNT_W'(HDR_WORDS - 1);
    localparam logic [CNT_W-1:0] BURST_CAP_C = CNT_W'(BURST_CAP);
    localparam logic [SEL_W-1:0] WR_BUF_RST  = SEL_W'(1 % NUM_BUF);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        ADDR,
        DATA,
        DROP,
        ACCEPT,
        WAIT
    } state_t;

    typedef enum logic [0:0] {
        C_IDLE  = 1'b0,
        C_ISSUE = 1'b1
    } c_state_t;

    state_t   state_reg, state_next;
    c_state_t c_state_reg, c_state_next;

    // Registered upstream word/enable
    logic [31:0] data_reg;
    logic        en_reg;

    // Packet parsing state
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      l_reg;
    logic [31:0]      off_reg;
    logic [CNT_W-1:0] p_reg;
    logic [SEL_W-1:0] wr_buf_reg;
    logic [SEL_W-1:0] frame_select_reg;
    logic             frame_done_reg;
    logic [15:0]      pkt_cnt_reg;
    logic [15:0]      drop_cnt_reg;

    // Command engine state
    logic [CNT_W-1:0] rem_reg;
    logic [31:0]      addr_reg;

    // Control strobes from the main FSM
    logic cnt_clr;
    logic cnt_inc;
    logic latch_len;
    logic latch_addr;
    logic rotate;
    logic drop_inc;
    logic accept;

    logic        r_ack;
    logic        data_we;
    logic        ctrl_we;
    logic [3:0]  strb;
    logic        is_last;
    logic [2:0]  tail_bytes;
    logic [31:0] ceil_words;
    logic [31:0] p_full;
    logic        pkt_bad;
    logic [CNT_W-1:0] burst_w;
    logic [31:0] frame_addr;

    // Payload length in words excluding the offset word; the ceil is built
    // from the shifted length so it cannot overflow for L near 2^32.
    assign ceil_words = {2'b00, l_reg[31:2]} + {31'd0, |l_reg[1:0]};
    assign p_full     = ceil_words - 32'd1;
    assign pkt_bad    = (l_reg < 32'd8) || (p_full > 32'(MAX_PKT_WORDS));

    assign r_ack = (state_reg == IDLE) && (c_state_reg == C_IDLE);

    // Tail strobes: on the last payload word only the first L mod 4 lanes
    // carry data (all four when L is a multiple of 4).
    assign is_last    = (cnt_reg == p_reg - CNT_W'(1));
    assign tail_bytes = (l_reg[1:0] == 2'd0) ? 3'd4 : {1'b0, l_reg[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign strb[gi] = !is_last || (3'(gi) < tail_bytes);
        end
    endgenerate

    assign burst_w    = (rem_reg > BURST_CAP_C) ? BURST_CAP_C : rem_reg;
    assign frame_addr = FRAME_BASE + (32'(wr_buf_reg) * FRAME_STRIDE) + {off_reg[29:0], 2'b00};

    // Capture the upstream word and enable; parsing runs one cycle behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            en_reg   <= 1'b0;
        end else begin
            data_reg <= bus.r_data;
            en_reg   <= bus.r_enable;
        end
    end

    // Main FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Main FSM next-state and control strobes.
    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        latch_len  = 1'b0;
        latch_addr = 1'b0;
        rotate     = 1'b0;
        drop_inc   = 1'b0;
        accept     = 1'b0;
        data_we    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.r_enable && r_ack) begin
                    state_next = HEADER;
                    cnt_clr    = 1'b1;
                end
            end
            HEADER: begin
                if (!en_reg) begin
                    state_next = IDLE;
                    drop_inc   = 1'b1;
                end else begin
                    latch_len = (cnt_reg == LEN_IDX_C);
                    if (cnt_reg == HDR_LAST_C) begin
                        state_next = ADDR;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (!en_reg) begin
                    state_next = IDLE;
                    drop_inc   = 1'b1;
                end else begin
                    latch_addr = 1'b1;
                    if (pkt_bad) begin
                        state_next = DROP;
                    end else begin
                        state_next = DATA;
                        cnt_clr    = 1'b1;
                        rotate     = (data_reg == 32'd0);
                    end
                end
            end
            DATA: begin
                if (!en_reg) begin
                    state_next = IDLE;
                    drop_inc   = 1'b1;
                end else begin
                    data_we = 1'b1;
                    if (is_last) begin
                        state_next = ACCEPT;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DROP: begin
                drop_inc   = 1'b1;
                state_next = WAIT;
            end
            ACCEPT: begin
                accept     = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // Trailing words beyond the payload are ignored here.
                if (!bus.r_enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Packet datapath: counters, latched header fields, buffer rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg          <= '0;
            l_reg            <= '0;
            off_reg          <= '0;
            p_reg            <= '0;
            wr_buf_reg       <= WR_BUF_RST;
            frame_select_reg <= '0;
            frame_done_reg   <= 1'b0;
            pkt_cnt_reg      <= '0;
            drop_cnt_reg     <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (cnt_inc) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (latch_len) begin
                l_reg <= data_reg;
            end
            if (latch_addr) begin
                off_reg <= data_reg;
                p_reg   <= p_full[CNT_W-1:0];
            end
            // Rotation happens in ADDR so the address latched in ACCEPT
            // already points into the newly selected buffer.
            if (rotate) begin
                frame_select_reg <= wr_buf_reg;
                wr_buf_reg       <= wr_buf_reg + SEL_W'(1);
                frame_done_reg   <= 1'b1;
            end
            if (drop_inc) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
            if (accept) begin
                pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
            end
        end
    end

    // Command engine state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_state_reg <= C_IDLE;
        end else begin
            c_state_reg <= c_state_next;
        end
    end

    // Command engine next-state: push one burst per ready cycle.
    always_comb begin
        c_state_next = c_state_reg;
        ctrl_we      = 1'b0;
        case (c_state_reg)
            C_IDLE: begin
                if (accept) begin
                    c_state_next = C_ISSUE;
                end
            end
            C_ISSUE: begin
                ctrl_we = bus.ctrl_ready;
                if (bus.ctrl_ready && (rem_reg == burst_w)) begin
                    c_state_next = C_IDLE;
                end
            end
            default: c_state_next = C_IDLE;
        endcase
    end

    // Command datapath: remaining words and next byte address; both hold
    // while the command FIFO is not ready so ctrl_in stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg  <= '0;
            addr_reg <= '0;
        end else if (accept) begin
            rem_reg  <= p_reg;
            addr_reg <= frame_addr;
        end else if (ctrl_we) begin
            rem_reg  <= rem_reg - burst_w;
            addr_reg <= addr_reg + (32'(burst_w) << 2);
        end
    end

    assign bus.r_ack    = r_ack;
    assign bus.w_req    = 1'b0;
    assign bus.w_enable = 1'b0;
    assign bus.w_data   = 32'd0;
    assign bus.data_in  = {strb, data_reg};
    assign bus.data_we  = data_we;
    assign bus.ctrl_in  = {8'(burst_w), addr_reg};
    assign bus.ctrl_we  = ctrl_we;

    assign frame_select = frame_select_reg;
    assign frame_done   = frame_done_reg;
    assign pkt_cnt      = pkt_cnt_reg;
    assign drop_cnt     = drop_cnt_reg;

    // Inputs with no function in this receiver, and offset bits shifted out.
    logic unused_ok;
    assign unused_ok = ^{bus.r_req, bus.w_ack, off_reg[31:30]};

endmodule

// File: tb/tb_udp_frame_recv.sv
// Self-checking bench for udp_frame_recv (NUM_BUF=4). Each packet's expected
// data pushes, commands, counters and frame selection come from a
// packet-level reference model; DUT pushes are captured by a monitor.
module tb_udp_frame_recv;

    localparam int          NB      = 4;
    localparam int          HDR     = 4;
    localparam int          LIDX    = 3;
    localparam int          MAXB    = 64;
    localparam longint      MAXP    = 512;
    localparam logic [31:0] FB      = 32'h0000_0000;
    localparam logic [31:0] FS      = 32'h0200_0000;

    logic        clk;
    logic        rst;
    logic [1:0]  frame_select;
    logic        frame_done;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    udp_frame_recv_if bus();

    udp_frame_recv #(
        .NUM_BUF       (NB),
        .FRAME_BASE    (FB),
        .FRAME_STRIDE  (FS),
        .HDR_WORDS     (HDR),
        .LEN_IDX       (LIDX),
        .MAX_BURST     (MAXB),
        .MAX_PKT_WORDS (512)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .frame_select (frame_select),
        .frame_done   (frame_done),
        .pkt_cnt      (pkt_cnt),
        .drop_cnt     (drop_cnt)
    );

    int total;
    int bad;
    int fd_seen;
    bit bp_random;

    logic [35:0] got_data[$];
    logic [35:0] exp_data[$];
    logic [39:0] got_cmd[$];
    logic [39:0] exp_cmd[$];

    // Reference model state
    int          m_wr_buf;
    int          m_fs;
    int          m_fd;
    logic [15:0] m_pkt;
    logic [15:0] m_drop;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Monitor: record every FIFO push and frame_done pulse.
    initial begin
        fd_seen = 0;
        forever begin
            @(negedge clk);
            if (bus.data_we === 1'b1) got_data.push_back(bus.data_in);
            if (bus.ctrl_we === 1'b1) got_cmd.push_back(bus.ctrl_in);
            if (frame_done === 1'b1) fd_seen++;
        end
    end

    // Random command-FIFO backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_random) bus.ctrl_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int budget, input string tag);
        int n;
        n = 0;
        while (bus.r_ack !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(bus.r_ack), 64'd1);
    endtask

    // Send one packet. cut >= 0 forces the number of words sent (early
    // r_enable drop); stall > 0 holds ctrl_ready low that many cycles once
    // the command engine has started.
    task automatic run_pkt(input logic [31:0] len, input logic [31:0] off,
                           input int extra, input int cut, input int stall);
        longint      p;
        bit          valid;
        int          nwords;
        int          nlist;
        int          k;
        int          rem;
        int          n;
        logic [31:0] a;
        logic [3:0]  sb;
        logic [31:0] words[$];

        p     = (longint'(len) + 3) / 4 - 1;
        valid = (len >= 32'd8) && (p <= MAXP);
        nwords = valid ? HDR + 1 + int'(p) + extra : HDR + 1 + extra;
        if (cut >= 0) nwords = cut;
        nlist = (nwords > HDR + 1) ? nwords : HDR + 1;

        for (int i = 0; i < HDR; i++) words.push_back((i == LIDX) ? len : $urandom());
        words.push_back(off);
        while (words.size() < nlist) words.push_back($urandom());

        exp_data.delete();
        exp_cmd.delete();
        if (nwords <= HDR) begin
            m_drop++;
        end else if (!valid) begin
            m_drop++;
        end else begin
            if (off == 32'd0) begin
                m_fs     = m_wr_buf;
                m_wr_buf = (m_wr_buf + 1) % NB;
                m_fd++;
            end
            k = nwords - HDR - 1;
            if (longint'(k) > p) k = int'(p);
            for (int i = 0; i < k; i++) begin
                if (longint'(i) == p - 1 && len[1:0] != 2'd0)
                    sb = 4'((32'd1 << len[1:0]) - 32'd1);
                else
                    sb = 4'hF;
                exp_data.push_back({sb, words[HDR + 1 + i]});
            end
            if (longint'(k) < p) begin
                m_drop++;
            end else begin
                m_pkt++;
                a   = FB + 32'(m_wr_buf) * FS + (off << 2);
                rem = int'(p);
                while (rem > 0) begin
                    n = (rem > MAXB) ? MAXB : rem;
                    exp_cmd.push_back({8'(n), a});
                    a   = a + 32'(n * 4);
                    rem = rem - n;
                end
            end
        end

        wait_ack(3000, "r_ack_before_pkt");
        got_data.delete();
        got_cmd.delete();
        if (stall > 0) bus.ctrl_ready = 1'b0;

        for (int i = 0; i < nwords; i++) begin
            bus.r_enable = 1'b1;
            bus.r_data   = words[i];
            bus.r_req    = 1'($urandom_range(0, 1));
            step();
        end
        bus.r_enable = 1'b0;
        bus.r_data   = 32'd0;

        if (stall > 0) begin
            repeat (3) step();
            for (int i = 0; i < stall; i++) begin
                chk("stall_ctrl_we", 64'(bus.ctrl_we), 64'd0);
                chk("stall_r_ack", 64'(bus.r_ack), 64'd0);
                if (exp_cmd.size() > 0) chk("stall_ctrl_in", 64'(bus.ctrl_in), 64'(exp_cmd[0]));
                step();
            end
            bus.ctrl_ready = 1'b1;
        end

        wait_ack(3000, "r_ack_after_pkt");
        step();

        chk("n_data", 64'(got_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < exp_data.size(); i++)
            if (i < got_data.size()) chk("data_in", 64'(got_data[i]), 64'(exp_data[i]));
        chk("n_cmd", 64'(got_cmd.size()), 64'(exp_cmd.size()));
        for (int i = 0; i < exp_cmd.size(); i++)
            if (i < got_cmd.size()) chk("ctrl_in", 64'(got_cmd[i]), 64'(exp_cmd[i]));
        chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("frame_select", 64'(frame_select), 64'(m_fs));
        chk("frame_done_pulses", 64'(fd_seen), 64'(m_fd));

        $display("pkt L=%0d off=%0h sent=%0d data=%0d cmds=%0d pkt_cnt=%0d drop_cnt=%0d sel=%0d",
                 len, off, nwords, got_data.size(), got_cmd.size(), pkt_cnt, drop_cnt, frame_select);
    endtask

    task automatic model_reset();
        m_wr_buf = 1;
        m_fs     = 0;
        m_pkt    = 16'd0;
        m_drop   = 16'd0;
    endtask

    initial begin
        logic [31:0] rl;
        logic [31:0] ro;
        int          kind;

        total        = 0;
        bad          = 0;
        bp_random    = 1'b0;
        rst          = 1'b1;
        bus.r_req    = 1'b0;
        bus.r_enable = 1'b0;
        bus.r_data   = 32'd0;
        bus.w_ack    = 1'b0;
        bus.ctrl_ready = 1'b1;
        m_fd         = 0;
        model_reset();

        repeat (3) step();
        chk("rst_data_we", 64'(bus.data_we), 64'd0);
        chk("rst_ctrl_we", 64'(bus.ctrl_we), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_frame_select", 64'(frame_select), 64'd0);
        chk("rst_r_ack", 64'(bus.r_ack), 64'd1);
        chk("rst_w_req", 64'(bus.w_req), 64'd0);
        rst = 1'b0;
        step();

        // Directed packets
        run_pkt(32'd264, 32'h0, 0, -1, 0);          // 65 words, rotation, 64 + 1 split
        run_pkt(32'd14, 32'h10, 1, -1, 0);          // tail strobe 4'h3
        run_pkt(32'd4, 32'h0, 2, -1, 0);            // too short, offset 0 must not rotate
        run_pkt(32'd2056, 32'h0, 0, -1, 0);         // P = 513, too long
        run_pkt(32'hFFFF_FFFF, 32'h3, 0, -1, 0);    // ceil must not overflow
        run_pkt(32'd7, 32'h1, 0, -1, 0);            // L just below minimum
        run_pkt(32'd8, 32'h2, 0, -1, 0);            // minimum valid: one word
        run_pkt(32'd9, 32'h0, 2, -1, 0);            // tail strobe 4'h1, trailing words
        run_pkt(32'd11, 32'h4, 0, -1, 0);           // tail strobe 4'h7
        run_pkt(32'd2052, 32'h7, 0, -1, 0);         // P = 512 exactly
        run_pkt(32'd524, 32'h100, 0, -1, 10);       // 130 words under command stall
        for (int i = 0; i < 4; i++)
            run_pkt(32'd16 + 32'(4 * i), 32'h0, 0, -1, 0);  // rotation sequence
        run_pkt(32'd100, 32'h5, 0, 7, 0);           // r_enable drops mid-DATA
        run_pkt(32'd100, 32'h5, 0, 2, 0);           // r_enable drops mid-HEADER
        run_pkt(32'd100, 32'h0, 0, 4, 0);           // r_enable drops before offset
        run_pkt(32'd100, 32'hFFFF_FFF0, 0, -1, 0);  // address wrap on offset*4

        // Randomized packets with random backpressure
        bp_random = 1'b1;
        for (int i = 0; i < 20; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      rl = $urandom_range(0, 7);
            else if (kind == 1) rl = $urandom_range(2053, 2300);
            else                rl = $urandom_range(8, 600);
            ro = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            run_pkt(rl, ro, int'($urandom_range(0, 3)), -1, 0);
        end
        bp_random = 1'b0;
        step();
        bus.ctrl_ready = 1'b1;

        // Reset asserted in the middle of DATA
        wait_ack(3000, "r_ack_before_rst_pkt");
        for (int i = 0; i < 7; i++) begin
            bus.r_enable = 1'b1;
            bus.r_data   = (i == LIDX) ? 32'd40 : ((i == HDR) ? 32'h20 : $urandom());
            step();
        end
        chk("mid_data_we_before_rst", 64'(bus.data_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_data_we", 64'(bus.data_we), 64'd0);
        chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("mid_rst_frame_select", 64'(frame_select), 64'd0);
        chk("mid_rst_r_ack", 64'(bus.r_ack), 64'd1);
        chk("mid_rst_ctrl_we", 64'(bus.ctrl_we), 64'd0);
        $display("reset asserted during DATA");
        step();
        rst          = 1'b0;
        bus.r_enable = 1'b0;
        bus.r_data   = 32'd0;
        model_reset();
        step();
        run_pkt(32'd30, 32'h0, 0, -1, 0);
        run_pkt(32'd200, 32'h40, 1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
